serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in and borrow-out. Computes {bout,d} such that d = a - b - bin (mod 2^WIDTH).
- Inverse arithmetic companion to the team's parallel 4-bit adder; the identity a = d + b + bin (mod 2^WIDTH) holds for every result.
- Processes one bit per clock, LSB first, under a start/busy/done handshake.
- Used where area matters more than latency.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range is 2 or more.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: synchronous, active-low
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend; sampled on the accept edge
- b  in  WIDTH  subtrahend; sampled on the accept edge
- bin  in  1  borrow-in; sampled on the accept edge
- busy  out  1  high while the operation is in progress (RUN state)
- done  out  1  one-cycle pulse marking a valid result
- d  out  WIDTH  difference; registered, held until the next result
- bout  out  1  borrow-out; registered, held with d

Behaviour:
- Reset: one clock is the only clock. Reset is synchronous and active-low: rst_n=0 sampled on a rising clk edge takes effect on that edge.
  - Reset values: state=IDLE, busy=0, done=0, d=0, bout=0. Internal shift registers, borrow and counter are cleared.
  - Reset during RUN aborts the operation. No done pulse is produced and no partial result appears on d.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE:
    - On an edge with start=1, load a and b into shift registers, set borrow to bin, set cnt to 0, and go to RUN.
    - busy goes high in the following cycle.
  - RUN, each edge:
    - a0 = LSB of the a shift register; b0 = LSB of the b shift register; br = current borrow.
    - diff = a0 ^ b0 ^ br.
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
    - Shift diff into the MSB of the result register, shift both operand registers right by one, and increment cnt.
    - On the edge where cnt = WIDTH-1, the last bit is processed. Load d with the completed result, load bout with br_next, and go to DONE.
  - DONE:
    - done=1 and busy=0 for exactly one cycle; go to IDLE unconditionally on the next edge.
- Latency:
  - busy is high for exactly WIDTH cycles.
  - done rises WIDTH+1 edges after the accept edge.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Handshake rules:
  - start while busy=1 or done=1 is ignored and has no side effects. The requester must hold or re-assert start after done.
  - start held high continuously restarts the unit on the first IDLE cycle after done.
  - a, b and bin may change freely after the accept edge.
- Output stability: d and bout change only on the RUN→DONE edge and on reset. They are stable during busy.
- Width rules:
  - cnt is clog2(WIDTH) bits wide.
  - The result wraps mod 2^WIDTH.
  - bout=1 exactly when a < b + bin as unsigned integers.

Decomposition:
- Shared package/header sub_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH.
- One natural sub-module: full_subtractor (a, b, bin → diff, bout), purely combinational. It is instantiated once inside the serial datapath and can be reused by future parallel subtractors.

Test Plan:
1. WIDTH=4. a=9, b=3, bin=0, start pulsed → busy high for 4 cycles, done at edge 5 after accept, d=6, bout=0.
2. a=3, b=9, bin=0 → d=4'hA, bout=1. Check the adder identity 10+9 = 3 (mod 16).
3. Corner values:
   - a=0, b=0, bin=1 → d=4'hF, bout=1.
   - a=F, b=F, bin=1 → d=4'hF, bout=1.
   - a=F, b=0, bin=0 → d=F, bout=0.
4. Start a=9, b=3. Pulse start with a=1, b=1 on the 2nd RUN cycle and during DONE → both ignored; result d=6 only, exactly one done pulse.
5. Reset mid-operation: start a=7, b=2, then rst_n=0 for one edge on the 2nd RUN cycle → busy=0, done=0, d=0, bout=0 next cycle, no later done pulse. A fresh start afterwards gives d=5.
6. Exhaustive check at WIDTH=4: all 512 combinations of a, b, bin, back-to-back with start held high → every done pulse gives {bout,d} = a - b - bin. Also run a spot-check at WIDTH=8 with a=8'h00, b=8'h01 → d=8'hFF, bout=1, busy high for 8 cycles.

Source files
------------

// File: rtl/sub_pkg.sv
// ============================================================================
// Module   : sub_pkg
// Brief    : Shared state encoding and default width for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Brief    : One-bit combinational subtractor: diff = a - b - bin, with borrow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    logic w_axb;

    assign w_axb  = a_i ^ b_i;
    assign diff_o = w_axb ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~w_axb & bin_i);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial WIDTH-bit subtractor, LSB first, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the WIDTH-1 bits already produced; the final bit goes straight to d.
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;

    logic               w_diff;
    logic               w_br_next;

    full_subtractor u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .diff_o (w_diff),
        .bout_o (w_br_next)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d = (res_q >> 1) | ((WIDTH-1)'(w_diff) << (WIDTH-2));
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = w_br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    d_d     = {w_diff, res_q};
                    bout_d  = w_br_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign d    = d_q;
    assign bout = bout_q;

endmodule

`default_nettype wire
